// File: rtl/collision_tracker.sv
// collision_tracker: per-frame collision engine for ship, asteroids and bullets.
// Overlaps seen during a frame are accumulated and then latched on the frame strobe.
// The latched results drive hit pulses, a saturating score and an asteroid-hit event queue.
// Optional ship invulnerability window: define COLLISION_SHIP_INVULN_EN.
module collision_tracker #(
    parameter int N_AST         = 10,
    parameter int N_BUL         = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int SCORE_W       = 10,
    parameter int SCORE_MAX     = 999,
    parameter int ID_W          = (N_AST > 1) ? $clog2(N_AST) : 1,
    parameter int INVULN_FRAMES = 60
) (
    input  logic               clk_pix,
    input  logic               reset_n,
    input  logic               frame,
    input  logic               de,
    input  logic               ship_drawing,
    input  logic [N_AST-1:0]   ast_drawing,
    input  logic [N_BUL-1:0]   bul_drawing,
    output logic [N_AST-1:0]   ast_hit,
    output logic [N_BUL-1:0]   bul_hit,
    output logic               ship_hit,
    output logic [SCORE_W-1:0] score,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic               evt_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int POP_W = $clog2(N_AST + 1);
    localparam int SUM_W = ((SCORE_W > POP_W) ? SCORE_W : POP_W) + 1;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_t;

    logic [N_AST-1:0] acc_ast;
    logic [N_BUL-1:0] acc_bul;
    logic             acc_ship;
    logic             any_ast;
    logic             any_bul;

    logic [POP_W-1:0]   acc_pop;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_next;

    scan_state_t      state;
    scan_state_t      state_next;
    logic [N_AST-1:0] scan_vec;
    logic [ID_W-1:0]  scan_idx;
    logic             scan_last;
    logic             push;
    logic             drop_scan;

    logic [ID_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             pop;
    logic             wr_en;
    logic             lost;

    assign any_ast = |ast_drawing;
    assign any_bul = |bul_drawing;

    // Accumulate visible-region overlaps; the frame strobe clears them as they are latched
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            acc_ast  <= '0;
            acc_bul  <= '0;
            acc_ship <= 1'b0;
        end else if (frame) begin
            acc_ast  <= '0;
            acc_bul  <= '0;
            acc_ship <= 1'b0;
        end else if (de) begin
            acc_ast  <= acc_ast | (ast_drawing & {N_AST{any_bul}});
            acc_bul  <= acc_bul | (bul_drawing & {N_BUL{any_ast}});
            acc_ship <= acc_ship | (ship_drawing & any_ast);
        end
    end

    // Asteroid and bullet hits are one-cycle pulses following the frame strobe
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            ast_hit <= '0;
            bul_hit <= '0;
        end else if (frame) begin
            ast_hit <= acc_ast;
            bul_hit <= acc_bul;
        end else begin
            ast_hit <= '0;
            bul_hit <= '0;
        end
    end

`ifdef COLLISION_SHIP_INVULN_EN
    localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    logic [INV_W-1:0] invuln_cnt;

    // Ship hit with an invulnerability window counted in frames after each registered hit
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            ship_hit   <= 1'b0;
            invuln_cnt <= '0;
        end else if (frame) begin
            if (invuln_cnt != '0) begin
                invuln_cnt <= invuln_cnt - INV_W'(1);
                ship_hit   <= 1'b0;
            end else if (acc_ship) begin
                invuln_cnt <= INV_W'(INVULN_FRAMES);
                ship_hit   <= 1'b1;
            end else begin
                ship_hit   <= 1'b0;
            end
        end
    end
`else
    logic unused_invuln;
    assign unused_invuln = (INVULN_FRAMES != 0);

    // Ship hit level follows the accumulated ship overlap of the previous frame
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            ship_hit <= 1'b0;
        end else if (frame) begin
            ship_hit <= acc_ship;
        end
    end
`endif

    // Population count of shot asteroids and the saturated score candidate
    always_comb begin
        acc_pop = '0;
        for (int unsigned i = 0; i < N_AST; i++) begin
            acc_pop = acc_pop + POP_W'(acc_ast[i]);
        end
        score_sum  = SUM_W'(score) + SUM_W'(acc_pop);
        score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                      : score_sum[SCORE_W-1:0];
    end

    // Score register, updated once per frame strobe
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            score <= '0;
        end else if (frame) begin
            score <= score_next;
        end
    end

    // Scanner next state and push decision; a new frame restarts any scan in progress
    always_comb begin
        state_next = state;
        push       = 1'b0;
        drop_scan  = 1'b0;
        scan_last  = (scan_idx == ID_W'(N_AST - 1));
        if (state == S_SCAN) begin
            push = scan_vec[scan_idx];
        end
        if (frame) begin
            drop_scan  = (state == S_SCAN);
            state_next = (|acc_ast) ? S_SCAN : S_IDLE;
        end else if ((state == S_SCAN) && scan_last) begin
            state_next = S_IDLE;
        end
    end

    // Scanner state, latched vector and index
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            scan_vec <= '0;
            scan_idx <= '0;
        end else begin
            state <= state_next;
            if (frame) begin
                scan_vec <= acc_ast;
                scan_idx <= '0;
            end else if (state == S_SCAN) begin
                scan_idx <= scan_last ? '0 : scan_idx + ID_W'(1);
            end
        end
    end

    assign evt_valid = (fifo_cnt != '0);
    assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pop       = evt_valid & evt_ready;
    assign wr_en     = push & (~fifo_full | pop);
    assign lost      = push & fifo_full & ~pop;
    assign evt_id    = fifo_mem[rd_ptr];

    // Event queue storage; a push into a full queue is accepted only alongside a pop
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (wr_en) begin
            fifo_mem[wr_ptr] <= scan_idx;
        end
    end

    // Event queue pointers, occupancy and sticky loss flag
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (lost || drop_scan) begin
                evt_overflow <= 1'b1;
            end
        end
    end

endmodule
